// File: rtl/full_adder_fa_comb.sv
// Single-bit full adder: purely combinational sum and carry.
module fa_comb (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/full_adder.sv
// Full adder with an optional output register stage selected by OUT_REG.
module full_adder #(
    parameter int OUT_REG = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    input  logic in_valid,
    output logic sum_out,
    output logic carry_out,
    output logic out_valid
);

    logic sum_p0;
    logic carry_p0;
    logic vld_p0;

    // Stage 0: combinational add
    fa_comb u_fa_comb (
        .a     (a_in),
        .b     (b_in),
        .c     (c_in),
        .sum   (sum_p0),
        .carry (carry_p0)
    );

    assign vld_p0 = in_valid;

    generate
        if (OUT_REG != 0) begin : g_reg
            logic sum_p1;
            logic carry_p1;
            logic vld_p1;

            // Stage 1: result register; data loads only on valid cycles so
            // undriven inputs during idle cycles never reach the outputs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_p1   <= 1'b0;
                    carry_p1 <= 1'b0;
                    vld_p1   <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        sum_p1   <= sum_p0;
                        carry_p1 <= carry_p0;
                    end
                end
            end

            assign sum_out   = sum_p1;
            assign carry_out = carry_p1;
            assign out_valid = vld_p1;
        end else begin : g_comb
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst};

            assign sum_out   = sum_p0;
            assign carry_out = carry_p0;
            assign out_valid = vld_p0;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Directed-vector bench for full_adder, registered and combinational variants.
module tb_full_adder;

    logic clk;
    logic rst;
    logic a_in;
    logic b_in;
    logic c_in;
    logic in_valid;
    logic sum_r, carry_r, vld_r;
    logic sum_c, carry_c, vld_c;

    int checks;
    int failures;

    // Hand-computed {carry,sum} for {a,b,c} = 0..7
    logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    full_adder #(.OUT_REG(1)) dut_reg (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .in_valid  (in_valid),
        .sum_out   (sum_r),
        .carry_out (carry_r),
        .out_valid (vld_r)
    );

    full_adder #(.OUT_REG(0)) dut_comb (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .in_valid  (in_valid),
        .sum_out   (sum_c),
        .carry_out (carry_c),
        .out_valid (vld_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] abc, input logic v);
        a_in     = abc[2];
        b_in     = abc[1];
        c_in     = abc[0];
        in_valid = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(3'b111, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({carry_r, sum_r, vld_r} !== 3'b000) begin
                failures++;
                $display("FAIL reset_cycle%0d got c/s/v=%b%b%b want 000", k, carry_r, sum_r, vld_r);
            end
        end
        checks++;
        if ({carry_c, sum_c, vld_c} !== 3'b111) begin
            failures++;
            $display("FAIL reset_comb got c/s/v=%b%b%b want 111", carry_c, sum_c, vld_c);
        end
    endtask

    task automatic test_sweep();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v3;
            v3 = 3'(i);
            drive(v3, 1'b1);
            #1;
            checks++;
            if ({carry_c, sum_c} !== exp_tab[i] || vld_c !== 1'b1) begin
                failures++;
                $display("FAIL sweep_comb_%0d got cs=%b%b v=%b want cs=%b v=1", i, carry_c, sum_c, vld_c, exp_tab[i]);
            end
            step();
            checks++;
            if ({carry_r, sum_r} !== exp_tab[i] || vld_r !== 1'b1) begin
                failures++;
                $display("FAIL sweep_reg_%0d got cs=%b%b v=%b want cs=%b v=1", i, carry_r, sum_r, vld_r, exp_tab[i]);
            end
        end
    endtask

    task automatic test_hold();
        rst = 1'b0;
        drive(3'b110, 1'b1);
        step();
        checks++;
        if ({carry_r, sum_r, vld_r} !== 3'b101) begin
            failures++;
            $display("FAIL hold_load got c/s/v=%b%b%b want 101", carry_r, sum_r, vld_r);
        end
        drive(3'b000, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({carry_r, sum_r, vld_r} !== 3'b100) begin
                failures++;
                $display("FAIL hold_idle%0d got c/s/v=%b%b%b want 100", k, carry_r, sum_r, vld_r);
            end
        end
        a_in = 1'bx;
        b_in = 1'bz;
        c_in = 1'bx;
        step();
        checks++;
        if ({carry_r, sum_r, vld_r} !== 3'b100) begin
            failures++;
            $display("FAIL hold_xin got c/s/v=%b%b%b want 100", carry_r, sum_r, vld_r);
        end
    endtask

    task automatic test_reset_midstream();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v3;
            logic [2:0] want;
            v3 = 3'(i);
            rst = (i == 5);
            drive(v3, 1'b1);
            step();
            want = (i == 5) ? 3'b000 : {exp_tab[i], 1'b1};
            checks++;
            if ({carry_r, sum_r, vld_r} !== want) begin
                failures++;
                $display("FAIL midrst_%0d got c/s/v=%b%b%b want %b", i, carry_r, sum_r, vld_r, want);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_comb();
        drive(3'b101, 1'b1);
        for (int k = 0; k < 2; k++) begin
            rst = (k == 0);
            #1;
            checks++;
            if ({carry_c, sum_c, vld_c} !== 3'b101) begin
                failures++;
                $display("FAIL comb_rst%0d got c/s/v=%b%b%b want 101", 1 - k, carry_c, sum_c, vld_c);
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (vld_c !== 1'b0) begin
            failures++;
            $display("FAIL comb_vld_low got v=%b want 0", vld_c);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq [4] = '{3'b011, 3'b000, 3'b111, 3'b100};
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(seq[i], 1'b1);
            step();
            checks++;
            if ({carry_r, sum_r, vld_r} !== {exp_tab[seq[i]], 1'b1}) begin
                failures++;
                $display("FAIL b2b_%0d got c/s/v=%b%b%b want %b1", i, carry_r, sum_r, vld_r, exp_tab[seq[i]]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({carry_r, sum_r, vld_r} !== 3'b010) begin
            failures++;
            $display("FAIL b2b_drain got c/s/v=%b%b%b want 010", carry_r, sum_r, vld_r);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(3'b000, 1'b0);
        test_reset();
        test_sweep();
        test_hold();
        test_reset_midstream();
        test_comb();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The block SHALL have parameter OUT_REG, default 1; 1 = registered outputs, one-cycle latency; 0 = combinational outputs, zero latency.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port a_in  input  1  addend bit A.
REQ-006 Port b_in  input  1  addend bit B.
REQ-007 Port c_in  input  1  carry-in bit.
REQ-008 Port in_valid  input  1  qualifies a_in/b_in/c_in for the current cycle.
REQ-009 Port sum_out  output  1  sum bit.
REQ-010 Port carry_out  output  1  carry-out bit.
REQ-011 Port out_valid  output  1  qualifies sum_out/carry_out.

Function
REQ-012 The block SHALL compute sum = a_in XOR b_in XOR c_in.
REQ-013 The block SHALL compute carry = (a_in AND b_in) OR (a_in AND c_in) OR (b_in AND c_in).
REQ-014 Equivalently, {carry_out,sum_out} SHALL equal the 2-bit unsigned value a_in+b_in+c_in, range 0..3, with no overflow possible.
REQ-015 With OUT_REG=1, sum_out/carry_out SHALL update on the rising clk edge where in_valid=1, from the inputs sampled at that edge.
REQ-016 With OUT_REG=1, sum_out/carry_out SHALL hold their last values on edges where in_valid=0.
REQ-017 With OUT_REG=1, out_valid SHALL equal in_valid delayed by one clk cycle.
REQ-018 With OUT_REG=0, sum_out/carry_out SHALL follow the inputs combinationally, and out_valid SHALL equal in_valid.
REQ-019 Back-to-back valid inputs SHALL be accepted every cycle with no stall; there is no backpressure.
REQ-020 X/Z on data inputs while in_valid=0 SHALL NOT propagate to the registered outputs.

Reset
REQ-021 With OUT_REG=1 and rst=1 at a rising clk edge, sum_out, carry_out and out_valid SHALL all be 0 after that edge, regardless of in_valid.
REQ-022 Reset SHALL take priority over a simultaneous in_valid; data presented in a reset cycle SHALL be discarded.
REQ-023 The first valid result after reset is deasserted SHALL appear one cycle after the first in_valid=1 edge with rst=0.
REQ-024 With OUT_REG=0, rst SHALL have no effect on the outputs.

Structure
REQ-025 No shared package SHALL be required, because the block has no typedefs or constants beyond OUT_REG.
REQ-026 The combinational sum/carry logic SHALL be a single sub-module, fa_comb, instantiated once.
REQ-027 The output register stage SHALL be built with a generate on OUT_REG.

Verification
REQ-028 Reset check: hold rst=1 for 2 cycles with a_in=b_in=c_in=1 and in_valid=1 -> sum_out=0, carry_out=0, out_valid=0.
REQ-029 Exhaustive sweep: drive {a_in,b_in,c_in}=0..7, one per cycle, with in_valid=1 -> one cycle later {carry_out,sum_out} = 00,01,01,10,01,10,10,11 and out_valid=1.
REQ-030 Hold check: apply 1,1,0 valid, then in_valid=0 with inputs 0,0,0 -> outputs stay carry=1, sum=0 and out_valid=0.
REQ-031 Reset mid-stream: during the sweep, assert rst at input 5 -> outputs 0 on the next cycle, and the sweep resumes correctly after rst is released.
REQ-032 Combinational variant: with OUT_REG=0, apply 1,0,1 -> carry_out=1 and sum_out=0 in the same cycle, unaffected by rst.
